// File: rtl/pc_if.sv
// Bundle of control inputs and PC-state outputs between the core's control logic and pc_unit.
// The align_fault signal exists only when PC_ALIGN_CHECK_EN is defined.
interface pc_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jmp;
    logic [WIDTH-1:0] jmp_target;
    logic             exc_req;
    logic [WIDTH-1:0] exc_pc;
    logic             eret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] epc;
    logic             in_exc;
    logic             redirect;
`ifdef PC_ALIGN_CHECK_EN
    logic             align_fault;
`endif

    modport master (
        output stall, br_taken, br_target, jmp, jmp_target, exc_req, exc_pc, eret,
`ifdef PC_ALIGN_CHECK_EN
        input  align_fault,
`endif
        input  pc, pc_plus, epc, in_exc, redirect
    );

    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target, exc_req, exc_pc, eret,
`ifdef PC_ALIGN_CHECK_EN
        output align_fault,
`endif
        output pc, pc_plus, epc, in_exc, redirect
    );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection, EPC and in-exception state.
// Optional misaligned-target trap is enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
    parameter int               INC       = 4
) (
    input  logic   clk,
    input  logic   rst,
    pc_if.slave    bus
);

    typedef enum logic {RUN = 1'b0, EXC = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             redirect_q, redirect_d;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] target;
`ifdef PC_ALIGN_CHECK_EN
    logic             align_fault_q, align_fault_d;
`endif

    assign pc_plus = pc_q + WIDTH'(INC);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        target     = bus.jmp ? bus.jmp_target : bus.br_target;
`ifdef PC_ALIGN_CHECK_EN
        align_fault_d = 1'b0;
`endif
        if (bus.exc_req && state_q == RUN) begin
            epc_d      = bus.exc_pc;
            pc_d       = EXC_VEC;
            state_d    = EXC;
            redirect_d = 1'b1;
        end else if (bus.eret && state_q == EXC) begin
            pc_d       = epc_q;
            state_d    = RUN;
            redirect_d = 1'b1;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.jmp || bus.br_taken) begin
            redirect_d = 1'b1;
            pc_d       = target & ~WIDTH'(3);
`ifdef PC_ALIGN_CHECK_EN
            // A misaligned target traps, unless already in the handler where it is just masked.
            if (target[1:0] != 2'b00) begin
                align_fault_d = 1'b1;
                if (state_q == RUN) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VEC;
                    state_d = EXC;
                end
            end
`endif
        end else begin
            pc_d = pc_plus;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            redirect_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_fault_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
`ifdef PC_ALIGN_CHECK_EN
            align_fault_q <= align_fault_d;
`endif
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus  = pc_plus;
    assign bus.epc      = epc_q;
    assign bus.in_exc   = (state_q == EXC);
    assign bus.redirect = redirect_q;
`ifdef PC_ALIGN_CHECK_EN
    assign bus.align_fault = align_fault_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven self-checking bench for pc_unit with a scoreboard queue of expected states.
// Covers both builds; expectations for PC_ALIGN_CHECK_EN follow the same macro.
module tb_pc_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_if #(.WIDTH(W)) bus ();

    pc_unit #(
        .WIDTH    (W),
        .RESET_VEC(32'h0000_3000),
        .EXC_VEC  (32'h0000_4180),
        .INC      (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic         rst, stall, br, jmp, exc, eret;
        logic [W-1:0] brt, jt, xpc;
        logic [W-1:0] e_pc, e_epc;
        logic         e_in, e_red, e_af;
    } vec_t;

    typedef struct {
        logic [W-1:0] pc, epc;
        logic         in_exc, red, af;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic r, logic s, logic b, logic [W-1:0] bt, logic j,
                                logic [W-1:0] jt, logic x, logic [W-1:0] xp, logic e,
                                logic [W-1:0] p, logic [W-1:0] ep, logic ie, logic rd,
                                logic af);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.brt = bt; v.jmp = j; v.jt = jt;
        v.exc = x; v.xpc = xp; v.eret = e;
        v.e_pc = p; v.e_epc = ep; v.e_in = ie; v.e_red = rd; v.e_af = af;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, n_vec, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        rst            = v.rst;
        bus.stall      = v.stall;
        bus.br_taken   = v.br;
        bus.br_target  = v.brt;
        bus.jmp        = v.jmp;
        bus.jmp_target = v.jt;
        bus.exc_req    = v.exc;
        bus.exc_pc     = v.xpc;
        bus.eret       = v.eret;
        e.pc = v.e_pc; e.epc = v.e_epc; e.in_exc = v.e_in; e.red = v.e_red; e.af = v.e_af;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pc", bus.pc, e.pc);
            check("pc_plus", bus.pc_plus, e.pc + 32'd4);
            check("epc", bus.epc, e.epc);
            check("in_exc", {31'd0, bus.in_exc}, {31'd0, e.in_exc});
            check("redirect", {31'd0, bus.redirect}, {31'd0, e.red});
`ifdef PC_ALIGN_CHECK_EN
            check("align_fault", {31'd0, bus.align_fault}, {31'd0, e.af});
`endif
        end
    endtask

    // Shorthand for a cycle with only optional control lines.
    task automatic idle(input logic s, input logic [W-1:0] p, input logic [W-1:0] ep,
                        input logic ie, input logic rd);
        apply(mk(0, s, 0, 0, 0, 0, 0, 0, 0, p, ep, ie, rd, 0));
    endtask

    initial begin
        //         rst s  br brt           j  jt            x  xpc           e    pc            epc           in rd af
        vecs.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_3000, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_3004, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_3008, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,            1, 32'h3100,     0, 0,            0, 32'h0000_3008, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,            1, 32'h3100,     0, 0,            0, 32'h0000_3008, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            1, 32'h3100,     0, 0,            0, 32'h0000_3100, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_3104, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h3200,     0, 0,            0, 0,            0, 32'h0000_3200, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h3200,     1, 32'h3300,     0, 0,            0, 32'h0000_3300, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h3400,     0, 0,            0, 0,            0, 32'h0000_3300, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h300C,     0, 32'h0000_4180, 32'h300C,     1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h4184,     0, 32'h0000_4184, 32'h300C,     1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            1, 32'h0000_300C, 32'h300C,     0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            1, 32'h0000_3010, 32'h300C,     0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0,            1, 32'h3500,     1, 32'h3010,     1, 32'h0000_4180, 32'h3010,     1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,            1, 32'h3500,     1, 32'h5000,     1, 32'h0000_3010, 32'h3010,     0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,            0, 0,            1, 32'h3020,     0, 32'h0000_4180, 32'h3020,     1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0,            1, 32'h0000_3020, 32'h3020,     0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            1, 32'hFFFF_FFFC,0, 0,            0, 32'hFFFF_FFFC, 32'h3020,     0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_0000, 32'h3020,     0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_0004, 32'h3020,     0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            1, 32'h3000,     0, 0,            0, 32'h0000_3000, 32'h3020,     0, 1, 0));
`ifdef PC_ALIGN_CHECK_EN
        vecs.push_back(mk(0, 0, 1, 32'h3102,     0, 0,            0, 0,            0, 32'h0000_4180, 32'h3000,     1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_4184, 32'h3000,     1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            1, 32'h3203,     0, 0,            0, 32'h0000_3200, 32'h3000,     1, 1, 1));
`else
        vecs.push_back(mk(0, 0, 1, 32'h3102,     0, 0,            0, 0,            0, 32'h0000_3100, 32'h3020,     0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 32'h0000_3104, 32'h3020,     0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0,            1, 32'h3203,     0, 0,            0, 32'h0000_3200, 32'h3020,     0, 1, 0));
`endif
        vecs.push_back(mk(1, 1, 0, 0,            1, 32'h3500,     1, 32'h7000,     1, 32'h0000_3000, 32'h0,        0, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Long stall holds PC, then sequential flow resumes without a redirect.
        for (int k = 0; k < 4; k++) idle(1, 32'h3000, 32'h0, 0, 0);
        idle(0, 32'h3004, 32'h0, 0, 0);

        // Exception under stall, handler stalls, then eret under stall returns.
        apply(mk(0, 1, 0, 0, 0, 0, 1, 32'h3004, 0, 32'h0000_4180, 32'h3004, 1, 1, 0));
        idle(1, 32'h4180, 32'h3004, 1, 0);
        idle(0, 32'h4184, 32'h3004, 1, 0);
        apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0000_3004, 32'h3004, 0, 1, 0));
        idle(0, 32'h3008, 32'h3004, 0, 0);

        // Reset while in the handler clears EPC and the state bit.
        apply(mk(0, 0, 0, 0, 0, 0, 1, 32'h3008, 0, 32'h0000_4180, 32'h3008, 1, 1, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_3000, 32'h0, 0, 0, 0));

        if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
